instruction_fetch_stage: RTL
============================

Name: instruction_fetch_stage

Overview:
- Front end of the MIPS pipeline, directly upstream of the opcode decoder.
- Holds the program counter and drives the instruction-memory address.
- Captures the fetched word into the IF/ID pipeline register, whose Instruction output feeds the decoder.
- Handles stall (hazard hold) and redirect (taken branch / jump / jr) with flush of the wrong-path word.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush/reset (sll $0,$0,0).

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Stall  input  1  hold PC and IF/ID (load-use hazard)
- Redirect  input  1  taken branch/jump resolved downstream
- RedirectTarget  input  32  new PC on Redirect
- IMemAddr  output  32  instruction memory address (= PC, combinational from PC register)
- IMemData  input  32  instruction word at IMemAddr, combinational read
- IF_ID_Instruction  output  32  registered instruction to decoder
- IF_ID_PCPlus4  output  32  registered PC+4 of that instruction
- IF_ID_Valid  output  1  registered: IF/ID holds a real instruction
- MisalignedRedirect  output  1  registered one-cycle pulse: RedirectTarget[1:0] != 0

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high: while Reset=1, PC=RESET_PC, IF_ID_Instruction=NOP_WORD, IF_ID_PCPlus4=0, IF_ID_Valid=0, MisalignedRedirect=0, state=BOOT.
- State machine (2 bits): BOOT, RUN, HOLD.
  - BOOT: first edge after reset release. PC <= PC+4. IF/ID loads IMemData with Valid=1. -> RUN. Stall is ignored in BOOT; Redirect is honoured.
  - RUN: per-edge priority Redirect > Stall > normal.
  - HOLD: entered from RUN on Stall=1 with Redirect=0. Stays while Stall=1. Returns to RUN when Stall=0, performing a normal advance on that edge.
- Normal advance: PC <= PC+4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000). IF_ID_Instruction <= IMemData. IF_ID_PCPlus4 <= PC+4. IF_ID_Valid <= 1.
- Stall: PC and all IF/ID fields hold their value exactly.
- Redirect (any state, including during Stall):
  - PC <= {RedirectTarget[31:2],2'b00}.
  - IF_ID_Instruction <= NOP_WORD, IF_ID_Valid <= 0; IF_ID_PCPlus4 holds.
  - State -> RUN.
  - MisalignedRedirect <= (RedirectTarget[1:0] != 0). It is 0 on every non-redirect edge.
- Redirect and Stall together: Redirect wins. The stalled word is discarded.
- Latency: IMemData at PC appears on IF_ID_Instruction one edge later. Redirect target word appears two edges after Redirect is sampled; exactly one NOP bubble.
- Reset asserted mid-stall or mid-redirect: immediate asynchronous return to the reset values above. No partial update.
- IMemAddr is always the current PC. It never glitches to PC+4 during Stall.

Optional Feature:
- Macro FETCH_PERF_COUNT_EN.
- Defined: adds two 32-bit outputs, FetchCount and FlushCount.
  - FetchCount increments on each normal advance, including BOOT.
  - FlushCount increments on each Redirect edge.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, IMem[0]=0x20080005, IMem[4]=0x8D090000 -> edge1: IF_ID_Instruction=0x20080005, PCPlus4=4, Valid=1, PC=4; edge2: Instruction=0x8D090000, PC=8.
- Stall high for 3 cycles at PC=0x10 -> IMemAddr stays 0x10, IF/ID unchanged for 3 edges, PC=0x14 after Stall drops.
- Redirect=1, RedirectTarget=0x40 at PC=0x18 -> next edge PC=0x40, Instruction=0, Valid=0; following edge Instruction=IMem[0x40], PCPlus4=0x44.
- Redirect=1 and Stall=1 same edge, target 0x80 -> PC=0x80, Valid=0, state RUN (not HOLD).
- RedirectTarget=0x43 -> PC=0x40, MisalignedRedirect=1 for exactly one cycle.
- PC=0xFFFF_FFFC, normal advance -> PC=0x0000_0000, PCPlus4=0. Reset pulse mid-stall -> all outputs at reset values asynchronously; with FETCH_PERF_COUNT_EN, both counters are 0.

Source files
------------

// File: rtl/instruction_fetch_stage_if.sv
// Bus between the fetch stage and its neighbours: hazard/redirect control, the
// instruction-memory port and the IF/ID register outputs.
interface instruction_fetch_stage_if;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        MisalignedRedirect;

  modport master (
    output Stall, Redirect, RedirectTarget, IMemData,
    input  IMemAddr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, MisalignedRedirect
  );

  modport slave (
    input  Stall, Redirect, RedirectTarget, IMemData,
    output IMemAddr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, MisalignedRedirect
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC register, IF/ID pipeline register, stall hold and redirect flush.
// Optional fetch/flush counters are compiled in with FETCH_PERF_COUNT_EN.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                         Clk,
  input  logic                         Reset,
`ifdef FETCH_PERF_COUNT_EN
  output logic [31:0]                  FetchCount,
  output logic [31:0]                  FlushCount,
`endif
  instruction_fetch_stage_if.slave     bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic        misaligned_q, misaligned_d;
  logic        advance;
  logic        flush;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pcplus4_d    = pcplus4_q;
    valid_d      = valid_q;
    misaligned_d = 1'b0;
    advance      = 1'b0;
    flush        = 1'b0;

    // Redirect outranks Stall in every state; BOOT alone ignores Stall.
    if (bus.Redirect) begin
      flush   = 1'b1;
      state_d = RUN;
    end else begin
      case (state_q)
        BOOT: begin
          advance = 1'b1;
          state_d = RUN;
        end
        RUN, HOLD: begin
          if (bus.Stall) begin
            state_d = HOLD;
          end else begin
            advance = 1'b1;
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    if (flush) begin
      pc_d         = {bus.RedirectTarget[31:2], 2'b00};
      instr_d      = NOP_WORD;
      valid_d      = 1'b0;
      misaligned_d = (bus.RedirectTarget[1:0] != 2'b00);
    end else if (advance) begin
      pc_d      = pc_plus4;
      instr_d   = bus.IMemData;
      pcplus4_d = pc_plus4;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_WORD;
      pcplus4_q    <= 32'd0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pcplus4_q    <= pcplus4_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (advance) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (flush)   flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

  assign bus.IMemAddr           = pc_q;
  assign bus.IF_ID_Instruction  = instr_q;
  assign bus.IF_ID_PCPlus4      = pcplus4_q;
  assign bus.IF_ID_Valid        = valid_q;
  assign bus.MisalignedRedirect = misaligned_q;

endmodule
